// File: rtl/paddle_sched.sv
// Pong paddle controller: picks each paddle's move source (buttons or CPU tracking),
// applies a hold-to-accelerate step ramp and runs the recentre sequence between rallies.
module paddle_sched #(
    parameter int unsigned Y_MIN       = 0,
    parameter int unsigned Y_MAX       = 480,
    parameter int unsigned Y_CENTER    = 240,
    parameter int unsigned STEP_MAX    = 4,
    parameter int unsigned RAMP_FRAMES = 8,
    parameter int unsigned DEAD_ZONE   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       run,
    input  logic       recenter,
    input  logic       up_l_n,
    input  logic       down_l_n,
    input  logic       up_r_n,
    input  logic       down_r_n,
    input  logic       cpu_r,
    input  logic [9:0] ball_y,
    output logic [9:0] y_pos_l,
    output logic [9:0] y_pos_r,
    output logic       busy,
    output logic       update
);

    localparam int unsigned HoldMax = STEP_MAX * RAMP_FRAMES;
    localparam int unsigned HoldW   = $clog2(HoldMax + 1);

    localparam logic [10:0] YMin    = 11'(Y_MIN);
    localparam logic [10:0] YMax    = 11'(Y_MAX);
    localparam logic [10:0] YCtr    = 11'(Y_CENTER);
    localparam logic [10:0] StepMax = 11'(STEP_MAX);
    localparam logic [10:0] DeadZ   = 11'(DEAD_ZONE);
    localparam logic [9:0]  YCtr10  = 10'(Y_CENTER);

    typedef enum logic [1:0] {StHold, StPlay, StCenter} state_e;
    typedef enum logic [1:0] {DirNone, DirUp, DirDown} dir_e;

    typedef struct packed {
        logic [9:0]       y;
        logic [HoldW-1:0] hold;
    } move_t;

    state_e           state_q;
    logic [HoldW-1:0] hold_l_q, hold_r_q;
    dir_e             last_l_q, last_r_q;

    dir_e             dir_l, dir_r;
    move_t            mv_l, mv_r;
    logic [9:0]       ctr_l, ctr_r;

    function automatic dir_e btn_dir(input logic up_n, input logic dn_n);
        case ({up_n, dn_n})
            2'b10:   return DirDown;
            2'b01:   return DirUp;
            default: return DirNone;
        endcase
    endfunction

    function automatic dir_e cpu_dir(input logic [9:0] ball, input logic [9:0] y);
        logic [10:0] b;
        logic [10:0] p;
        b = {1'b0, ball};
        p = {1'b0, y};
        if (b > p + DeadZ) return DirDown;
        if (b + DeadZ < p) return DirUp;
        return DirNone;
    endfunction

    // A new or absent direction restarts the ramp before the step is taken.
    function automatic move_t ramp_move(input logic [9:0] y, input logic [HoldW-1:0] hold,
                                        input dir_e dir, input dir_e last);
        logic [HoldW-1:0] eff;
        int unsigned      step_i;
        logic [10:0]      step;
        logic [10:0]      p;
        move_t            m;
        eff    = (dir == DirNone || dir != last) ? '0 : hold;
        step_i = 1 + 32'(eff) / RAMP_FRAMES;
        if (step_i > STEP_MAX) step_i = STEP_MAX;
        step = 11'(step_i);
        p    = {1'b0, y};
        case (dir)
            DirDown: p = (p + step > YMax) ? YMax : p + step;
            DirUp:   p = (p < YMin + step) ? YMin : p - step;
            default: ;
        endcase
        m.y    = p[9:0];
        m.hold = (dir == DirNone) ? '0 : (32'(eff) >= HoldMax) ? eff : eff + 1'b1;
        return m;
    endfunction

    function automatic logic [9:0] center_move(input logic [9:0] y);
        logic [10:0] p;
        p = {1'b0, y};
        if (p + StepMax <= YCtr)      p = p + StepMax;
        else if (p < YCtr)            p = YCtr;
        else if (p >= YCtr + StepMax) p = p - StepMax;
        else                          p = YCtr;
        return p[9:0];
    endfunction

    always_comb begin
        dir_l = btn_dir(up_l_n, down_l_n);
        dir_r = cpu_r ? cpu_dir(ball_y, y_pos_r) : btn_dir(up_r_n, down_r_n);
        mv_l  = ramp_move(y_pos_l, hold_l_q, dir_l, last_l_q);
        mv_r  = ramp_move(y_pos_r, hold_r_q, dir_r, last_r_q);
        ctr_l = center_move(y_pos_l);
        ctr_r = center_move(y_pos_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StHold;
            y_pos_l  <= YCtr10;
            y_pos_r  <= YCtr10;
            hold_l_q <= '0;
            hold_r_q <= '0;
            last_l_q <= DirNone;
            last_r_q <= DirNone;
            busy     <= 1'b0;
            update   <= 1'b0;
        end else begin
            update <= 1'b0;
            case (state_q)
                StHold: begin
                    hold_l_q <= '0;
                    hold_r_q <= '0;
                    last_l_q <= DirNone;
                    last_r_q <= DirNone;
                    if (recenter) begin
                        state_q <= StCenter;
                        busy    <= 1'b1;
                    end else if (run) begin
                        state_q <= StPlay;
                    end
                end
                StPlay: begin
                    // Leaving PLAY swallows a coincident frame_tick.
                    if (recenter || !run) begin
                        state_q  <= recenter ? StCenter : StHold;
                        busy     <= recenter;
                        hold_l_q <= '0;
                        hold_r_q <= '0;
                        last_l_q <= DirNone;
                        last_r_q <= DirNone;
                    end else if (frame_tick) begin
                        y_pos_l  <= mv_l.y;
                        y_pos_r  <= mv_r.y;
                        hold_l_q <= mv_l.hold;
                        hold_r_q <= mv_r.hold;
                        last_l_q <= dir_l;
                        last_r_q <= dir_r;
                        update   <= (mv_l.y != y_pos_l) || (mv_r.y != y_pos_r);
                    end
                end
                StCenter: begin
                    hold_l_q <= '0;
                    hold_r_q <= '0;
                    last_l_q <= DirNone;
                    last_r_q <= DirNone;
                    if (y_pos_l == YCtr10 && y_pos_r == YCtr10) begin
                        state_q <= StHold;
                        busy    <= 1'b0;
                    end else if (frame_tick) begin
                        y_pos_l <= ctr_l;
                        y_pos_r <= ctr_r;
                        update  <= (ctr_l != y_pos_l) || (ctr_r != y_pos_r);
                    end
                end
                default: begin
                    state_q <= StHold;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_paddle_sched.sv
// Scoreboard bench for paddle_sched: expected positions are queued per frame_tick and
// popped by a monitor on every update pulse.
module tb_paddle_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic       run = 1'b0;
    logic       recenter = 1'b0;
    logic       up_l_n = 1'b1;
    logic       down_l_n = 1'b1;
    logic       up_r_n = 1'b1;
    logic       down_r_n = 1'b1;
    logic       cpu_r = 1'b0;
    logic [9:0] ball_y = '0;
    logic [9:0] y_pos_l, y_pos_r;
    logic       busy, update;

    paddle_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .run        (run),
        .recenter   (recenter),
        .up_l_n     (up_l_n),
        .down_l_n   (down_l_n),
        .up_r_n     (up_r_n),
        .down_r_n   (down_r_n),
        .cpu_r      (cpu_r),
        .ball_y     (ball_y),
        .y_pos_l    (y_pos_l),
        .y_pos_r    (y_pos_r),
        .busy       (busy),
        .update     (update)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    // Reference positions and ramp trackers (consecutive same-direction ticks).
    int ml = 240, mr = 240;
    int cl = 0, cr = 0;
    int pl = 0, pr = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && update) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update: got l=%0d r=%0d expected no update",
                         y_pos_l, y_pos_r);
            end else begin
                mon_e = exp_q.pop_front();
                check("update_l", int'(y_pos_l), int'(mon_e[19:10]));
                check("update_r", int'(y_pos_r), int'(mon_e[9:0]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic do_tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    // d: 0 none, 1 down, -1 up, 2 both pressed
    task automatic drive(input int d, output logic up_n, output logic dn_n);
        up_n = !(d == -1 || d == 2);
        dn_n = !(d == 1 || d == 2);
    endtask

    task automatic model_side(inout int y, inout int cnt, inout int prev, input int d);
        int e, step;
        e = (d == 2) ? 0 : d;
        if (e == 0) begin
            cnt  = 0;
            prev = 0;
        end else begin
            if (e != prev) cnt = 0;
            step = 1 + cnt / 8;
            if (step > 4) step = 4;
            if (e > 0) y = (y + step > 480) ? 480 : y + step;
            else       y = (y - step < 0) ? 0 : y - step;
            cnt  = (cnt < 32) ? cnt + 1 : 32;
            prev = e;
        end
    endtask

    task automatic play_ticks(input int n, input int dl, input int dr);
        int old_l, old_r;
        for (int i = 0; i < n; i++) begin
            drive(dl, up_l_n, down_l_n);
            drive(dr, up_r_n, down_r_n);
            old_l = ml;
            old_r = mr;
            model_side(ml, cl, pl, dl);
            model_side(mr, cr, pr, dr);
            if (ml != old_l || mr != old_r) exp_q.push_back({10'(ml), 10'(mr)});
            do_tick();
        end
        up_l_n = 1'b1; down_l_n = 1'b1; up_r_n = 1'b1; down_r_n = 1'b1;
    endtask

    function automatic int toward(input int y);
        if (y < 240) return (y + 4 > 240) ? 240 : y + 4;
        if (y > 240) return (y - 4 < 240) ? 240 : y - 4;
        return y;
    endfunction

    task automatic center_ticks(input int n);
        int old_l, old_r;
        for (int i = 0; i < n; i++) begin
            old_l = ml;
            old_r = mr;
            ml = toward(ml);
            mr = toward(mr);
            if (ml != old_l || mr != old_r) exp_q.push_back({10'(ml), 10'(mr)});
            do_tick();
        end
    endtask

    task automatic reset_ramp();
        cl = 0; cr = 0; pl = 0; pr = 0;
    endtask

    task automatic drain(input string name);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_y_l", int'(y_pos_l), 240);
        check("reset_y_r", int'(y_pos_r), 240);
        check("reset_busy", int'(busy), 0);
        check("reset_update", int'(update), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run = 1'b1;
        @(posedge clk); #1;

        play_ticks(5, 0, 0);
        drain("idle_drain");
        check("idle_y_l", int'(y_pos_l), 240);
        check("idle_y_r", int'(y_pos_r), 240);
        check("idle_busy", int'(busy), 0);

        play_ticks(10, 1, 0);
        drain("ramp_drain");
        check("ramp_l", int'(y_pos_l), 252);
        play_ticks(1, 0, 0);
        play_ticks(1, 1, 0);
        drain("repress_drain");
        check("repress_l", int'(y_pos_l), 253);
        play_ticks(1, 1, 0);
        play_ticks(80, -1, 0);
        drain("clamp_lo_drain");
        check("clamp_lo_l", int'(y_pos_l), 0);

        play_ticks(2, 0, -1);
        play_ticks(72, 0, 1);
        drain("ramp_r_drain");
        check("ramp_r", int'(y_pos_r), 478);
        play_ticks(1, 0, 1);
        drain("clamp_hi_drain");
        check("clamp_hi_r", int'(y_pos_r), 480);
        play_ticks(3, 0, 1);
        drain("hold_hi_drain");
        check("hold_hi_r", int'(y_pos_r), 480);

        play_ticks(3, 2, 0);
        drain("both_drain");
        check("both_l", int'(y_pos_l), 0);

        // run drops on a frame_tick with a button held: no move, then HOLD ignores ticks
        down_l_n = 1'b0;
        run = 1'b0;
        do_tick();
        do_tick();
        do_tick();
        down_l_n = 1'b1;
        drain("run_drop_drain");
        check("run_drop_l", int'(y_pos_l), 0);
        reset_ramp();
        run = 1'b1;
        @(posedge clk); #1;

        recenter = 1'b1;
        @(posedge clk); #1;
        recenter = 1'b0;
        check("rc1_busy", int'(busy), 1);
        center_ticks(10);
        recenter = 1'b1;
        @(posedge clk); #1;
        recenter = 1'b0;
        center_ticks(50);
        drain("rc1_drain");
        check("rc1_l", int'(y_pos_l), 240);
        check("rc1_r", int'(y_pos_r), 240);
        check("rc1_done_busy", int'(busy), 0);

        cpu_r = 1'b1;
        ball_y = 10'd300;
        up_r_n = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back({10'd240, 10'(240 + i)});
            do_tick();
        end
        ball_y = 10'd242;
        do_tick();
        do_tick();
        ball_y = 10'd100;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back({10'd240, 10'(243 - i)});
            do_tick();
        end
        cpu_r = 1'b0;
        up_r_n = 1'b1;
        drain("cpu_drain");
        check("cpu_r_final", int'(y_pos_r), 240);
        reset_ramp();

        play_ticks(47, -1, 0);
        drain("pos_l_drain");
        check("pos_l", int'(y_pos_l), 100);
        play_ticks(52, 0, 1);
        drain("pos_r_drain");
        check("pos_r", int'(y_pos_r), 400);

        // recenter coincident with frame_tick and a held button: no move that cycle
        down_l_n = 1'b1;
        up_l_n = 1'b0;
        recenter = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        recenter = 1'b0;
        frame_tick = 1'b0;
        up_l_n = 1'b1;
        run = 1'b0;
        check("rc2_busy", int'(busy), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_ramp();
        center_ticks(35);
        drain("rc2_mid_drain");
        check("rc2_l", int'(y_pos_l), 240);
        check("rc2_r_mid", int'(y_pos_r), 260);
        check("rc2_mid_busy", int'(busy), 1);
        center_ticks(5);
        drain("rc2_end_drain");
        check("rc2_r", int'(y_pos_r), 240);
        check("rc2_done_busy", int'(busy), 0);
        down_l_n = 1'b0;
        do_tick();
        do_tick();
        down_l_n = 1'b1;
        drain("hold_drain");
        check("hold_l", int'(y_pos_l), 240);

        run = 1'b1;
        @(posedge clk); #1;
        play_ticks(27, -1, 0);
        drain("pre_rst_drain");
        check("pre_rst_l", int'(y_pos_l), 180);
        recenter = 1'b1;
        @(posedge clk); #1;
        recenter = 1'b0;
        check("pre_rst_busy", int'(busy), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_y_l", int'(y_pos_l), 240);
        check("rst_y_r", int'(y_pos_r), 240);
        check("rst_busy", int'(busy), 0);
        check("rst_update", int'(update), 0);
        ml = 240;
        mr = 240;
        reset_ramp();
        run = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        down_l_n = 1'b0;
        do_tick();
        do_tick();
        down_l_n = 1'b1;
        drain("post_rst_drain");
        check("post_rst_l", int'(y_pos_l), 240);
        run = 1'b1;
        @(posedge clk); #1;
        play_ticks(1, 1, 0);
        drain("post_rst_play_drain");
        check("post_rst_play_l", int'(y_pos_l), 241);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
